// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage ahead of the CONTROL decoder. Holds the PC, issues one word
// fetch at a time to instruction memory and parks each returned word in a
// one-entry output register that drives the decoder. A taken branch
// redirects the PC and flushes the output register and any response still
// in flight.
//
// Ports
//   CLK, RESET_N          clock, synchronous active-low reset
//   imem_req/imem_addr    fetch strobe (combinational) and byte address
//   imem_rvalid/rdata     memory response
//   instr_valid/ready     output register handshake with decode
//   instruction/instr_pc  held word and its byte address
//   redirect_valid/pc     taken-branch redirect
//   fetch_misalign        sticky flag: redirect target not word aligned
//
// Optional build macro IFU_PERF_CNT_EN adds perf_fetched / perf_stall
// counters as extra outputs.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    localparam int unsigned XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            CLK,
    input  logic            RESET_N,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_misalign
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_stall
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic            mis_q, mis_d;
    logic            fetch_ok;

    // Next-state, fetch strobe and output-register update
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        ipc_d     = ipc_q;
        mis_d     = mis_q;
        imem_req  = 1'b0;
        imem_addr = '0;
        fetch_ok  = (state_q == IDLE) && !mis_q && (!valid_q || instr_ready);

        if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            mis_d   = |redirect_pc[1:0];
            // A request still in flight must have its response swallowed
            state_d = ((state_q != IDLE) && !imem_rvalid) ? DROP : IDLE;
        end else begin
            // Consume first so a same-edge load below overrides it
            if (valid_q && instr_ready) begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
            case (state_q)
                IDLE: begin
                    // Gated by RESET_N so nothing is issued while held in reset
                    if (fetch_ok && RESET_N) begin
                        imem_req  = 1'b1;
                        imem_addr = pc_q;
                        pc_d      = pc_q + WORD_BYTES;
                        state_d   = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr_d = imem_rdata;
                        ipc_d   = pc_q - WORD_BYTES;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            ipc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            mis_q   <= mis_d;
        end
    end

    assign instr_valid    = valid_q;
    assign instruction    = instr_q;
    assign instr_pc       = ipc_q;
    assign fetch_misalign = mis_q;

`ifdef IFU_PERF_CNT_EN
    logic word_load;
    assign word_load = (state_q == WAIT) && imem_rvalid && !redirect_valid;

    // Free-running event counters; only reset clears them
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            perf_fetched <= perf_fetched + XLEN'(word_load);
            perf_stall   <= perf_stall + XLEN'(valid_q && !instr_ready);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit. A transaction-level model (PC,
// one-outstanding flag, kill flag, held word) predicts every output each
// cycle; hand-computed literals pin the key scenarios. A second instance
// with RESET_PC=FFFF_FFFC covers PC wrap.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rvalid, ready, redir;
    logic [31:0] rdata, rpc;
    logic        req, valid, mis;
    logic [31:0] addr, instr, ipc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] pf, ps, w_pf, w_ps;
`endif

    instr_fetch_unit u_dut (
        .CLK(clk), .RESET_N(rst_n),
        .imem_req(req), .imem_addr(addr),
        .imem_rvalid(rvalid), .imem_rdata(rdata),
        .instr_valid(valid), .instr_ready(ready),
        .instruction(instr), .instr_pc(ipc),
        .redirect_valid(redir), .redirect_pc(rpc),
        .fetch_misalign(mis)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetched(pf), .perf_stall(ps)
`endif
    );

    // Wrap instance: ideal 1-cycle memory, always ready
    logic        w_req, w_valid, w_mis;
    logic [31:0] w_addr, w_instr, w_ipc;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata  = 32'h0;
    always @(posedge clk) begin
        w_rvalid <= w_req;
        w_rdata  <= ~w_addr;
    end

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .CLK(clk), .RESET_N(rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .instr_valid(w_valid), .instr_ready(1'b1),
        .instruction(w_instr), .instr_pc(w_ipc),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .fetch_misalign(w_mis)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetched(w_pf), .perf_stall(w_ps)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (32'hA000_0000 | a);
    endfunction

    // Memory responder state
    bit          pend = 0, spur = 0;
    int          cnt = 0, lat = 1;
    logic [31:0] pend_addr = 0;
    int          n_req = 0;
    logic [31:0] last_addr = 0;
    logic [31:0] w_log [4];
    int          w_n = 0;

    // Transaction-level model
    logic [31:0] m_pc = 32'h0, m_req_pc = 32'h0, m_instr = NOP, m_ipc = 32'h0;
    bit          m_busy = 0, m_kill = 0, m_valid = 0, m_mis = 0;
    logic [31:0] m_fetched = 0, m_stall = 0;
    bit          exp_req;

    task automatic tick(input bit do_cmp = 1'b1);
        rvalid = 1'b0;
        rdata  = 32'h0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                rvalid = 1'b1;
                rdata  = mem_word(pend_addr);
                pend   = 1'b0;
            end
        end
        if (spur && !rvalid) begin
            rvalid = 1'b1;
            rdata  = 32'hDEAD_BEEF;
        end
        spur = 1'b0;
        @(negedge clk);
        exp_req = rst_n && !redir && !m_busy && !m_mis && (!m_valid || ready);
        if (do_cmp) begin
            check32("imem_req", 32'(req), 32'(exp_req));
            if (exp_req) check32("imem_addr", addr, m_pc);
            check32("instr_valid", 32'(valid), 32'(m_valid));
            check32("instruction", instr, m_instr);
            check32("instr_pc", ipc, m_ipc);
            check32("fetch_misalign", 32'(mis), 32'(m_mis));
`ifdef IFU_PERF_CNT_EN
            check32("perf_fetched", pf, m_fetched);
            check32("perf_stall", ps, m_stall);
`endif
        end
        if (w_req && w_n < 4) begin
            w_log[w_n] = w_addr;
            w_n++;
        end
        if (req) begin
            pend      = 1'b1;
            cnt       = lat;
            pend_addr = addr;
            n_req++;
            last_addr = addr;
        end
        // Model update for this edge
        if (!rst_n) begin
            m_pc = 32'h0; m_busy = 0; m_kill = 0; m_valid = 0;
            m_instr = NOP; m_ipc = 32'h0; m_mis = 0;
            m_fetched = 0; m_stall = 0;
        end else begin
            if (m_valid && !ready) m_stall++;
            if (redir) begin
                m_pc = rpc; m_valid = 0; m_instr = NOP;
                m_mis = (rpc[1:0] != 2'b00);
                if (m_busy && !rvalid) m_kill = 1;
                else begin m_busy = 0; m_kill = 0; end
            end else begin
                if (m_valid && ready) begin m_valid = 0; m_instr = NOP; end
                if (m_busy && rvalid) begin
                    if (!m_kill) begin
                        m_valid = 1; m_instr = rdata; m_ipc = m_req_pc; m_fetched++;
                    end
                    m_busy = 0; m_kill = 0;
                end else if (exp_req) begin
                    m_req_pc = m_pc; m_pc = m_pc + 32'd4; m_busy = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k, n0;
        rst_n = 1'b0; ready = 1'b1; redir = 1'b0; rpc = 32'h0;
        rvalid = 1'b0; rdata = 32'h0;
        tick(1'b0);
        tick();
        check32("reset_instr", instr, NOP);
        check32("reset_valid", 32'(valid), 32'h0);
        rst_n = 1'b1;

        // 1: first fetch from reset, 1-cycle memory
        tick();
        check32("t1_first_addr", last_addr, 32'h0);
        check32("t1_nreq", 32'(n_req), 32'd1);
        tick();
        check32("t1_instr", instr, 32'h0050_0093);
        check32("t1_ipc", ipc, 32'h0);
        check32("t1_valid", 32'(valid), 32'h1);
        check32("t5_wrap_ipc", w_ipc, 32'hFFFF_FFFC);
        tick();
        check32("t1_next_addr", last_addr, 32'h4);

        // 5: wrap instance fetch order
        check32("t5_wrap_n", 32'(w_n), 32'd2);
        check32("t5_wrap_a0", w_log[0], 32'hFFFF_FFFC);
        check32("t5_wrap_a1", w_log[1], 32'h0);

        // 2: stall with word from pc 8
        k = 0;
        while (!(m_valid && m_ipc == 32'h8) && k < 20) begin tick(); k++; end
        if (k >= 20) timeout("t2_wait_pc8");
        ready = 1'b0;
        n0 = n_req;
        repeat (5) tick();
        check32("t2_instr_held", instr, 32'hA000_0008);
        check32("t2_ipc_held", ipc, 32'h8);
        check32("t2_no_req", 32'(n_req), 32'(n0));
        ready = 1'b1;
        tick();
        check32("t2_next_addr", last_addr, 32'hC);
        check32("t2_req_after", 32'(n_req), 32'(n0 + 1));

        // 3: redirect while a slow response is in flight
        lat = 3;
        k = 0;
        while (!m_busy && k < 20) begin tick(); k++; end
        if (k >= 20) timeout("t3_wait_busy");
        redir = 1'b1; rpc = 32'h40;
        tick();
        redir = 1'b0;
        check32("t3_valid_flush", 32'(valid), 32'h0);
        check32("t3_instr_nop", instr, NOP);
        n0 = n_req;
        k = 0;
        while (n_req == n0 && k < 20) begin tick(); k++; end
        if (k >= 20) timeout("t3_wait_req");
        check32("t3_redirect_addr", last_addr, 32'h40);

        // Redirect in the same cycle the response returns
        k = 0;
        while (m_busy && k < 20) begin tick(); k++; end
        if (k >= 20) timeout("t3b_wait_idle");
        lat = 1;
        k = 0;
        while (!m_busy && k < 20) begin tick(); k++; end
        if (k >= 20) timeout("t3b_wait_busy");
        redir = 1'b1; rpc = 32'h100;
        tick();
        redir = 1'b0;
        tick();
        check32("t3b_addr", last_addr, 32'h100);

        // 4: misaligned redirect, spurious response while idle
        k = 0;
        while (m_busy && k < 20) begin tick(); k++; end
        if (k >= 20) timeout("t4_wait_idle");
        redir = 1'b1; rpc = 32'h42;
        tick();
        redir = 1'b0;
        check32("t4_misalign", 32'(mis), 32'h1);
        n0 = n_req;
        repeat (4) tick();
        spur = 1'b1;
        repeat (6) tick();
        check32("t4_no_req", 32'(n_req), 32'(n0));
        redir = 1'b1; rpc = 32'h80;
        tick();
        redir = 1'b0;
        check32("t4_mis_clear", 32'(mis), 32'h0);
        tick();
        check32("t4_addr", last_addr, 32'h80);

        // Reset while waiting; late response lands in IDLE
        lat = 3;
        k = 0;
        while (!m_busy && k < 20) begin tick(); k++; end
        if (k >= 20) timeout("rst_wait_busy");
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check32("rst_refetch_addr", last_addr, 32'h0);
        repeat (4) tick();

        // Mixed traffic: varying latency and decode back-pressure
        for (int i = 0; i < 60; i++) begin
            ready = ((i % 3) != 0);
            lat   = 1 + (i % 2);
            tick();
        end
        ready = 1'b1;
        lat   = 1;

`ifdef IFU_PERF_CNT_EN
        // 6: three fetches then four stall cycles
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        k = 0;
        while (m_fetched != 32'd3 && k < 20) begin tick(); k++; end
        if (k >= 20) timeout("t6_wait_fetch");
        ready = 1'b0;
        repeat (4) tick();
        check32("t6_perf_fetched", pf, 32'd3);
        check32("t6_perf_stall", ps, 32'd4);
        ready = 1'b1;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
